// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default payload width and pointer-width helper.
package axis_pkg;

    localparam int AXIS_TDATA_WIDTH_DEFAULT = 32;

    // One extra bit beyond the address lets full and empty be told apart.
    function automatic int ptr_width(int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// FIFO storage: DEPTH x TDATA_WIDTH registers, synchronous write, asynchronous read, no reset.
module axis_fifo_mem #(
    parameter int TDATA_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [TDATA_WIDTH-1:0]   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [TDATA_WIDTH-1:0]   rdata
);

    logic [TDATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO with synchronous flush.
// Define AXIS_FIFO_COUNT_EN to add the `count` occupancy output.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH_DEFAULT,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   axis_sif_tvalid,
    input  logic [TDATA_WIDTH-1:0] axis_sif_tdata,
    output logic                   axis_sif_tready,
    output logic                   axis_mif_tvalid,
    output logic [TDATA_WIDTH-1:0] axis_mif_tdata,
    input  logic                   axis_mif_tready,
    input  logic                   invalidate
`ifdef AXIS_FIFO_COUNT_EN
    ,
    output logic [ptr_width(DEPTH)-1:0] count
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Flags come only from registered pointers, so tready never sees mif.tready.
    always_comb begin
        empty           = (wr_ptr_q == rd_ptr_q);
        full            = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        axis_sif_tready = !full && !rst;
        axis_mif_tvalid = !empty && !rst;
        push            = axis_sif_tvalid && axis_sif_tready;
        pop             = axis_mif_tvalid && axis_mif_tready;
    end

    // A flush wins over any same-cycle push or pop; the pushed beat is simply dropped.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (invalidate) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    axis_fifo_mem #(
        .TDATA_WIDTH(TDATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_q[AW-1:0]),
        .wdata(axis_sif_tdata),
        .raddr(rd_ptr_q[AW-1:0]),
        .rdata(axis_mif_tdata)
    );

`ifdef AXIS_FIFO_COUNT_EN
    assign count = rst ? '0 : (wr_ptr_q - rd_ptr_q);
`endif

endmodule
